// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Multi-channel byte-level UART transmitter. Sources hand over whole bytes
//   through valid/ready; a round-robin arbiter picks one byte per frame and
//   serialises it 8N1 onto a single line. With TAG_EN=1, a tag byte
//   {4'hF, ch} is sent before any data byte whose channel differs from the
//   previous data byte's channel. The tag is also sent for the first byte
//   after reset.
//
// Ports
//   clk_i       : clock
//   rst_i       : synchronous reset, active high
//   ch_valid_i  : per-channel byte valid
//   ch_data_i   : per-channel byte, channel k at [8k+7:8k]
//   ch_ready_o  : per-channel accept (one-hot or zero), combinational
//   txd_o       : serial output, idle high, registered
//   busy_o      : high while a frame (tag or data) is in progress
//   cur_ch_o    : channel of the most recently accepted byte
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int CLK_DIV = 217,
    parameter bit TAG_EN  = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_CH-1:0]   ch_valid_i,
    input  logic [NUM_CH*8-1:0] ch_data_i,
    output logic [NUM_CH-1:0]   ch_ready_o,
    output logic                txd_o,
    output logic                busy_o,
    output logic [3:0]          cur_ch_o
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, TAG_START, TAG_DATA, TAG_STOP, START, DATA, STOP
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [2:0]      r_bit_idx, w_bit_idx_nxt;
    logic [PW-1:0]   r_rr_ptr, w_rr_nxt;
    logic [3:0]      r_last_ch;
    logic            r_last_vld;
    logic [7:0]      r_byte;
    logic [3:0]      r_cur_ch;
    logic            r_txd;

    logic            w_found;
    logic [PW-1:0]   w_grant;
    logic            w_accept;
    logic            w_need_tag;
    logic            w_bit_end;
    logic            w_txd_nxt;
    logic [7:0]      w_tag;
    logic [3:0]      w_start_ch;

    // Round-robin search: scan offsets high to low so the lowest offset
    // from r_rr_ptr with a valid request is the one that sticks.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_grant = '0;
        idx     = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (ch_valid_i[idx]) begin
                w_found = 1'b1;
                w_grant = PW'(idx);
            end
        end
    end

    // Reset wins over an accept in the same cycle.
    assign w_accept   = (r_state == IDLE) && w_found && !rst_i;
    assign w_rr_nxt   = (int'(w_grant) == NUM_CH - 1) ? '0 : w_grant + 1'b1;
    assign w_need_tag = TAG_EN && (!r_last_vld || (r_last_ch != 4'(w_grant)));
    assign w_bit_end  = (r_bit_cnt == BIT_LAST);
    assign w_tag      = {4'hF, r_cur_ch};

    always_comb begin
        ch_ready_o = '0;
        for (int k = 0; k < NUM_CH; k++)
            ch_ready_o[k] = w_accept && (int'(w_grant) == k);
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_bit_idx_nxt = r_bit_idx;
        if (r_state != IDLE)
            w_bit_cnt_nxt = w_bit_end ? '0 : r_bit_cnt + 1'b1;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = w_need_tag ? TAG_START : START;
                    w_bit_cnt_nxt = '0;
                    w_bit_idx_nxt = '0;
                end
            end
            TAG_START: if (w_bit_end) begin
                w_state_nxt   = TAG_DATA;
                w_bit_idx_nxt = '0;
            end
            TAG_DATA: if (w_bit_end) begin
                if (r_bit_idx == 3'd7) w_state_nxt = TAG_STOP;
                else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
            end
            // Tag stop runs straight into the data start bit, no idle gap.
            TAG_STOP: if (w_bit_end) w_state_nxt = START;
            START: if (w_bit_end) begin
                w_state_nxt   = DATA;
                w_bit_idx_nxt = '0;
            end
            DATA: if (w_bit_end) begin
                if (r_bit_idx == 3'd7) w_state_nxt = STOP;
                else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
            end
            STOP: if (w_bit_end) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // txd is registered from the next state so the start bit appears the
    // cycle after the accept.
    always_comb begin
        w_txd_nxt = 1'b1;
        case (w_state_nxt)
            TAG_START, START: w_txd_nxt = 1'b0;
            TAG_DATA:         w_txd_nxt = w_tag[w_bit_idx_nxt];
            DATA:             w_txd_nxt = r_byte[w_bit_idx_nxt];
            default:          w_txd_nxt = 1'b1;
        endcase
    end

    // When START is entered directly from IDLE, r_cur_ch is being loaded on
    // the same edge, so take the channel from the grant instead.
    assign w_start_ch = (r_state == IDLE) ? 4'(w_grant) : r_cur_ch;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_rr_ptr   <= '0;
            r_last_ch  <= '0;
            r_last_vld <= 1'b0;
            r_byte     <= '0;
            r_cur_ch   <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_txd     <= w_txd_nxt;
            if (w_accept) begin
                r_byte   <= ch_data_i[int'(w_grant)*8 +: 8];
                r_cur_ch <= 4'(w_grant);
                r_rr_ptr <= w_rr_nxt;
            end
            if (w_state_nxt == START && r_state != START) begin
                r_last_ch  <= w_start_ch;
                r_last_vld <= 1'b1;
            end
        end
    end

    assign txd_o    = r_txd;
    assign busy_o   = (r_state != IDLE);
    assign cur_ch_o = r_cur_ch;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Self-checking bench. Each source channel is a byte queue. The reference
//   model keeps the expected serial line as a queue of bit levels (one entry
//   per clock). A byte accepted in an idle cycle appends its frames (an
//   optional tag frame, then the data frame) to that queue. The bench then
//   compares txd/busy/ready/cur_ch against the model on every cycle.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    localparam int NUM_CH  = 4;
    localparam int CLK_DIV = 4;
    localparam bit TAG_EN  = 1'b1;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic [NUM_CH-1:0]   ch_valid_i = '0;
    logic [NUM_CH*8-1:0] ch_data_i = '0;
    logic [NUM_CH-1:0]   ch_ready_o;
    logic                txd_o;
    logic                busy_o;
    logic [3:0]          cur_ch_o;

    uart_tx_arbiter #(.NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV), .TAG_EN(TAG_EN)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ch_valid_i (ch_valid_i),
        .ch_data_i  (ch_data_i),
        .ch_ready_o (ch_ready_o),
        .txd_o      (txd_o),
        .busy_o     (busy_o),
        .cur_ch_o   (cur_ch_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Sources and model state
    logic [7:0]        src_q[NUM_CH][$];
    logic [NUM_CH-1:0] gate = '1;
    bit                line_q[$];
    int                m_rr   = 0;
    int                m_last = -1;
    int                m_cur  = 0;
    bit                m_acc;
    int                m_grant;

    function automatic void push_frame(input logic [7:0] b);
        for (int k = 0; k < 10; k++) begin
            bit v;
            v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            repeat (CLK_DIV) line_q.push_back(v);
        end
    endfunction

    function automatic bit pending();
        bit p = 1'b0;
        for (int c = 0; c < NUM_CH; c++)
            if (gate[c] && src_q[c].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drive();
        for (int c = 0; c < NUM_CH; c++) begin
            ch_valid_i[c] = gate[c] && (src_q[c].size() > 0);
            ch_data_i[c*8 +: 8] = ch_valid_i[c] ? src_q[c][0] : 8'($urandom);
        end
    endtask

    // One clock: drive, check at negedge, update model, advance.
    task automatic tick();
        bit                exp_txd, exp_busy;
        logic [NUM_CH-1:0] exp_rdy;
        drive();
        @(negedge clk_i);
        if (line_q.size() > 0) begin
            exp_txd  = line_q.pop_front();
            exp_busy = 1'b1;
        end else begin
            exp_txd  = 1'b1;
            exp_busy = 1'b0;
        end
        chk("txd", 32'(txd_o), 32'(exp_txd));
        chk("busy", 32'(busy_o), 32'(exp_busy));
        chk("cur_ch", 32'(cur_ch_o), 32'(m_cur));
        exp_rdy = '0;
        m_acc   = 1'b0;
        m_grant = 0;
        if (!exp_busy && !rst_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                int c;
                c = (m_rr + k) % NUM_CH;
                if (!m_acc && ch_valid_i[c]) begin
                    m_acc   = 1'b1;
                    m_grant = c;
                end
            end
        end
        if (m_acc) begin
            exp_rdy[m_grant] = 1'b1;
            if (TAG_EN && m_grant != m_last) push_frame({4'hF, 4'(m_grant)});
            push_frame(src_q[m_grant][0]);
            m_last = m_grant;
            m_rr   = (m_grant + 1) % NUM_CH;
            m_cur  = m_grant;
        end
        chk("ready", 32'(ch_ready_o), 32'(exp_rdy));
        if (rst_i) begin
            line_q.delete();
            m_rr   = 0;
            m_last = -1;
            m_cur  = 0;
        end
        @(posedge clk_i);
        #1;
        if (m_acc) void'(src_q[m_grant].pop_front());
    endtask

    task automatic drain();
        int n = 0;
        gate = '1;
        while ((line_q.size() > 0 || pending()) && n < 5000) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < 5000), 32'd1);
        tick();
    endtask

    initial begin
        // Reset state
        rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        repeat (2) tick();

        // Single byte; first byte after reset is tagged
        src_q[0].push_back(8'hA5);
        drain();

        // ch1 sends 3C twice (one tag), then ch0 sends 7E (tagged again)
        src_q[1].push_back(8'h3C);
        src_q[1].push_back(8'h3C);
        drain();
        src_q[0].push_back(8'h7E);
        drain();

        // All channels continuously valid: grants rotate 0,1,2,3,...
        for (int c = 0; c < NUM_CH; c++)
            for (int j = 0; j < 3; j++) src_q[c].push_back(8'(8'h11 * (c + 1)));
        drain();

        // Only ch3, then ch0 and ch2 together: grants 3, 0, 2
        src_q[3].push_back(8'h5A);
        tick();
        src_q[0].push_back(8'h0F);
        src_q[2].push_back(8'hF0);
        drain();

        // Reset during bit 3 of a data frame, then ch1 must be tagged again
        src_q[2].push_back(8'hC3);
        tick();
        repeat (4 * CLK_DIV + 2) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        src_q[1].push_back(8'h96);
        drain();

        // Valid and reset in the same cycle: nothing accepted or sent
        src_q[2].push_back(8'hE7);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        src_q[2].delete();
        repeat (12) tick();

        // Randomized traffic with random valid gating and rare resets
        repeat (3000) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 15) == 0 && src_q[c].size() < 4)
                    src_q[c].push_back(8'($urandom));
                gate[c] = ($urandom_range(0, 3) != 0);
            end
            rst_i = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst_i = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
N-channel byte-level UART transmit arbiter and serialiser. It replaces the registered AND of independent UART TX lines, which corrupts frames when sources overlap. Each source channel hands over whole bytes through a valid/ready handshake, and a round-robin arbiter interleaves them frame-by-frame onto one 8N1 line. An optional per-switch tag byte identifies the source channel.

Parameters:
NUM_CH, 2, number of source channels; legal range 1..16.
CLK_DIV, 217, clk_i cycles per bit (25 MHz / 115200); minimum legal value 2.
TAG_EN, 0, when 1, a tag byte {4'hF, ch[3:0]} is sent before a data byte whose channel differs from the last channel sent.

Ports:
clk_i  input  1  single clock; all logic is synchronous to it.
rst_i  input  1  synchronous reset, active-high.
ch_valid_i  input  NUM_CH  per-channel byte-valid.
ch_data_i  input  NUM_CH*8  per-channel byte; channel k occupies bits [8k+7:8k].
ch_ready_o  output  NUM_CH  per-channel accept, one-hot or zero.
txd_o  output  1  serial output, idle high, registered.
busy_o  output  1  high whenever state != IDLE.
cur_ch_o  output  4  channel of the frame in progress; holds its value after the frame ends.

Behaviour:
- Reset (rst_i high at a clock edge):
  - Next cycle: txd_o=1, busy_o=0, ch_ready_o=0, cur_ch_o=0.
  - State=IDLE, rr_ptr=0, last_ch=invalid (the first byte after reset is tagged when TAG_EN=1).
  - Reset mid-frame aborts the frame. txd_o returns high on the next cycle, and the aborted byte is not retransmitted.
- States: IDLE, TAG_START, TAG_DATA, TAG_STOP, START, DATA, STOP.
  - Each bit lasts exactly CLK_DIV cycles, timed by a bit counter (0..CLK_DIV-1).
  - A bit index (0..7) steps through data bits LSB first.
- Arbitration:
  - In IDLE, grant goes to the first channel with ch_valid_i=1, searching from rr_ptr upward with wrap-around.
  - ch_ready_o[grant]=1 in that cycle only. ch_ready_o is combinational from state, rr_ptr and ch_valid_i.
  - Masters must not make valid depend on ready.
  - On accept (valid & ready): latch the byte and channel, set rr_ptr=grant+1 (mod NUM_CH), set cur_ch_o=grant.
  - Next state: TAG_START if TAG_EN=1 and grant != last_ch; otherwise START.
  - No valid in IDLE: remain in IDLE, txd_o=1.
- Latency: accept at cycle T gives txd_o=0 (the start bit) from T+1 for CLK_DIV cycles.
- Frame: start (0), 8 data bits LSB first, stop (1) = 10*CLK_DIV cycles.
  - The tag frame has the same format.
  - TAG_STOP goes directly to START with no idle gap.
  - last_ch is updated when the data frame begins.
- Throughput:
  - The final stop-bit cycle transitions to IDLE, and the next accept is possible in that IDLE cycle.
  - Back-to-back data frames start 10*CLK_DIV+1 cycles apart. The gap cycle drives txd_o=1.
- Data stability: the latched byte is unaffected by ch_data_i changes after the accept.
- Fairness: with all channels continuously valid, the grant sequence is 0,1,..,NUM_CH-1,0,...
- Simultaneous events: rst_i has priority over an accept in the same cycle. No byte is accepted, and ready is forced to 0 by reset.
- NUM_CH=1: arbitration degenerates. The tag is sent only for the first byte after reset.

Test Plan:
- Reset, CLK_DIV=4, NUM_CH=2, TAG_EN=0: ch0 sends 8'hA5 -> ready pulse for 1 cycle. txd_o low from next cycle for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4. busy_o=1 for 40 cycles.
- Both channels continuously valid (ch0=8'h11, ch1=8'h22), 4 bytes each -> frames in order 11,22,11,22,...; start bits 41 cycles apart; no ready pulse while busy_o=1.
- TAG_EN=1: ch1 sends 8'h3C twice, then ch0 sends 8'h7E -> serial bytes F1,3C,3C,F0,7E. Tag and data are contiguous; cur_ch_o is 1 then 0.
- rst_i asserted at bit 3 of a data frame -> txd_o=1 the next cycle, busy_o=0, rr_ptr=0. With TAG_EN=1, the next byte from ch1 is preceded by F1.
- ch_data_i changed one cycle after accept -> the serialised byte equals the value at accept. Valid and rst_i in the same cycle -> no ready, nothing transmitted.
- NUM_CH=4, only ch3 valid, then ch0 and ch2 valid together -> grants 3, then 0, then 2.
